// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x-oversampled start/data/parity/stop sampling,
// parity-checker load strobe and per-frame status pulses toward the rx FIFO.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic       par_err_in,
  output logic [7:0] rx_data,
  output logic       parity_bit,
  output logic       parity_load,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] HALF     = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL     = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // state is the observable FSM encoding for checkers bound to this block
  state_t     state, state_n;
  logic       sync1, sync2, line_prev;
  logic       fall;
  logic [3:0] sample_cnt, sample_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] rx_data_n;
  logic       parity_bit_n, parity_load_n;
  logic       data_valid_n, parity_error_n, framing_error_n;
  logic       par_flag, par_flag_n, load_d;

  assign fall = line_prev & ~sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  always_comb begin
    state_n         = state;
    sample_cnt_n    = sample_cnt;
    bit_cnt_n       = bit_cnt;
    rx_data_n       = rx_data;
    parity_bit_n    = parity_bit;
    parity_load_n   = 1'b0;
    data_valid_n    = 1'b0;
    parity_error_n  = 1'b0;
    framing_error_n = 1'b0;
    // checker result is taken one clk after the load strobe
    par_flag_n      = load_d ? par_err_in : par_flag;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n      = START;
          sample_cnt_n = 4'd0;
          par_flag_n   = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (sample_cnt == HALF) begin
            sample_cnt_n = 4'd0;
            if (!sync2) begin
              state_n   = DATA;
              bit_cnt_n = 3'd0;
              rx_data_n = 8'd0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            sample_cnt_n = sample_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (sample_cnt == FULL) begin
            sample_cnt_n       = 4'd0;
            rx_data_n[bit_cnt] = sync2;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_n = 3'd0;
              state_n   = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            sample_cnt_n = sample_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (sample_cnt == FULL) begin
            sample_cnt_n  = 4'd0;
            parity_bit_n  = sync2;
            parity_load_n = 1'b1;
            state_n       = STOP;
          end else begin
            sample_cnt_n = sample_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (sample_cnt == FULL) begin
            sample_cnt_n = 4'd0;
            state_n      = IDLE;
            if (sync2) begin
              data_valid_n   = 1'b1;
              parity_error_n = (PARITY_EN != 0) ? par_flag : 1'b0;
            end else begin
              framing_error_n = 1'b1;
            end
          end else begin
            sample_cnt_n = sample_cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sample_cnt    <= 4'd0;
      bit_cnt       <= 3'd0;
      rx_data       <= 8'd0;
      parity_bit    <= 1'b0;
      parity_load   <= 1'b0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      par_flag      <= 1'b0;
      load_d        <= 1'b0;
    end else begin
      state         <= state_n;
      sample_cnt    <= sample_cnt_n;
      bit_cnt       <= bit_cnt_n;
      rx_data       <= rx_data_n;
      parity_bit    <= parity_bit_n;
      parity_load   <= parity_load_n;
      data_valid    <= data_valid_n;
      parity_error  <= parity_error_n;
      framing_error <= framing_error_n;
      par_flag      <= par_flag_n;
      load_d        <= parity_load;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a parity build (8 data bits) and a
// no-parity build (7 data bits) driven with directed frames.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick;
  logic [1:0] tick_div = 2'd0;

  logic       rx1 = 1'b1, rx2 = 1'b1;
  logic       par_err1;
  logic [7:0] rx_data1, rx_data2;
  logic       parity_bit1, parity_bit2, parity_load1, parity_load2;
  logic       data_valid1, data_valid2, parity_error1, parity_error2;
  logic       framing_error1, framing_error2, busy1, busy2;

  int total = 0;
  int bad = 0;
  int load_cnt1 = 0, load_cnt2 = 0, ev_cnt1 = 0;

  // expected frame result {framing_error, parity_error, rx_data}
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];
  // expected checker load {parity_bit, rx_data}
  logic [8:0] exp_lq[$];

  // clock / reset / tick block
  always #5 clk = ~clk;
  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign baud_tick = (tick_div == 2'd3);

  // reference even-parity checker
  assign par_err1 = parity_bit1 ^ (^rx_data1);

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1)) dut_par (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx1),
    .par_err_in(par_err1), .rx_data(rx_data1), .parity_bit(parity_bit1),
    .parity_load(parity_load1), .data_valid(data_valid1),
    .parity_error(parity_error1), .framing_error(framing_error1), .busy(busy1)
  );

  uart_rx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0)) dut_nopar (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx2),
    .par_err_in(1'b0), .rx_data(rx_data2), .parity_bit(parity_bit2),
    .parity_load(parity_load2), .data_valid(data_valid2),
    .parity_error(parity_error2), .framing_error(framing_error2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (data_valid1 || framing_error1) begin
      ev_cnt1++;
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL par_unexpected: got fe=%0b pe=%0b data=0x%0h expected none",
                 framing_error1, parity_error1, rx_data1);
      end else begin
        check("par_frame", {22'd0, framing_error1, parity_error1, rx_data1}, {22'd0, exp_q1.pop_front()});
        check("par_busy_low", {31'd0, busy1}, 32'd0);
      end
    end
    if (parity_load1) begin
      load_cnt1++;
      if (exp_lq.size() == 0) begin
        total++; bad++;
        $display("FAIL load_unexpected: got par=%0b data=0x%0h expected none", parity_bit1, rx_data1);
      end else begin
        check("load_value", {23'd0, parity_bit1, rx_data1}, {23'd0, exp_lq.pop_front()});
      end
    end
    if (data_valid2 || framing_error2) begin
      if (exp_q2.size() == 0) begin
        total++; bad++;
        $display("FAIL nopar_unexpected: got fe=%0b data=0x%0h expected none", framing_error2, rx_data2);
      end else begin
        check("nopar_frame", {22'd0, framing_error2, parity_error2, rx_data2}, {22'd0, exp_q2.pop_front()});
      end
    end
    if (parity_load2) load_cnt2++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drivers
  task automatic send_frame1(input logic [7:0] d, input logic p, input logic stop, input int stop_clks);
    if (stop) exp_q1.push_back({1'b0, p ^ (^d), d});
    else      exp_q1.push_back({1'b1, 1'b0, d});
    exp_lq.push_back({p, d});
    @(negedge clk);
    rx1 = 1'b0; wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx1 = d[i]; wait_clks(BIT_CLKS);
    end
    rx1 = p; wait_clks(BIT_CLKS);
    rx1 = stop; wait_clks(stop_clks);
    rx1 = 1'b1;
  endtask

  task automatic send_frame2(input logic [6:0] d);
    exp_q2.push_back({2'b00, 1'b0, d});
    @(negedge clk);
    rx2 = 1'b0; wait_clks(BIT_CLKS);
    for (int i = 0; i < 7; i++) begin
      rx2 = d[i]; wait_clks(BIT_CLKS);
    end
    rx2 = 1'b1; wait_clks(BIT_CLKS);
  endtask

  initial begin
    int lc;
    int ec;
    wait_clks(5);
    check("reset_par_outs", {23'd0, rx_data1, parity_bit1, parity_load1, data_valid1,
          parity_error1, framing_error1, busy1}, 32'd0);
    check("reset_nopar_outs", {23'd0, rx_data2, parity_bit2, parity_load2, data_valid2,
          parity_error2, framing_error2, busy2}, 32'd0);
    rst_n = 1'b1;
    wait_clks(10);

    // good frame, correct parity
    send_frame1(8'hA5, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);
    check("a5_load_count", load_cnt1, 1);
    check("a5_rx_data_held", {24'd0, rx_data1}, 32'h0A5);

    // wrong parity bit -> parity_error with data_valid
    send_frame1(8'h01, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);

    // framing error with break held 3 bit times, then recovery
    send_frame1(8'h3C, 1'b0, 1'b0, 3 * BIT_CLKS);
    wait_clks(BIT_CLKS);
    check("break_busy_after", {31'd0, busy1}, 32'd0);
    send_frame1(8'h55, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);

    // start-bit glitch: low 4 ticks
    lc = load_cnt1;
    ec = ev_cnt1;
    @(negedge clk);
    rx1 = 1'b0; wait_clks(16);
    rx1 = 1'b1; wait_clks(2 * BIT_CLKS);
    check("glitch_no_load", load_cnt1, lc);
    check("glitch_no_event", ev_cnt1, ec);
    check("glitch_busy", {31'd0, busy1}, 32'd0);

    // reset during data bit 3 of 0xFF
    @(negedge clk);
    rx1 = 1'b0; wait_clks(BIT_CLKS);
    rx1 = 1'b1; wait_clks(3 * BIT_CLKS + BIT_CLKS / 2);
    check("pre_reset_busy", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {23'd0, rx_data1, parity_bit1, parity_load1, data_valid1,
          parity_error1, framing_error1, busy1}, 32'd0);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    send_frame1(8'h12, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);

    // no-parity build, back-to-back frames
    send_frame2(7'h7F);
    send_frame2(7'h00);
    wait_clks(BIT_CLKS);

    // bounded drain of the scoreboard
    for (int i = 0; i < 200 && (exp_q1.size() + exp_q2.size() + exp_lq.size()) != 0; i++)
      @(negedge clk);
    check("par_queue_empty", exp_q1.size(), 0);
    check("nopar_queue_empty", exp_q2.size(), 0);
    check("load_queue_empty", exp_lq.size(), 0);
    check("par_load_total", load_cnt1, 5);
    check("nopar_load_never", load_cnt2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART.
- Detects the start bit, samples data, parity and stop bits at 16x oversampling, and drives the parity checker.
- Strobes the checker's load with the assembled byte and the received parity bit, then reports frame completion, parity error and framing error to the host side.
- Sits between the rx pin synchronizer/baud generator and the rx FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8); rx_data is LSB-aligned, unused MSBs are 0.
- OVERSAMPLE, 16, baud_tick pulses per bit period.
- PARITY_EN, 1, 1 = frame carries a parity bit; 0 = PARITY state is skipped and parity_load is never asserted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-clk strobe, OVERSAMPLE per bit period.
- rx_in  in  1  raw serial line, idle high; synchronized internally with 2 flops.
- par_err_in  in  1  parity_bit_error returned by the parity checker.
- rx_data  out  8  assembled byte; also the checker's data input.
- parity_bit  out  1  sampled parity bit; the checker's rx_in.
- parity_load  out  1  one-clk strobe to the checker.
- data_valid  out  1  one-clk pulse: frame received with a good stop bit.
- parity_error  out  1  one-clk pulse, coincident with data_valid, when the checker flagged an error.
- framing_error  out  1  one-clk pulse when the stop bit samples 0.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sample_cnt=0, bit_cnt=0.
  - Synchronizer flops =1.
  - rx_data=0, parity_bit=0, all pulse outputs 0, busy=0.
- Reset mid-frame abandons the frame; no pulses are generated.
- Counters:
  - sample_cnt (4 bits) advances only on baud_tick.
  - bit_cnt counts 0..DATA_BITS-1.
- IDLE:
  - Falling edge of the synchronized line (previous 1, current 0) -> START, sample_cnt=0.
  - The edge is detected on any clk, not only on baud_tick.
- START:
  - At the tick where sample_cnt reaches OVERSAMPLE/2-1 (mid-bit): line=0 -> DATA with sample_cnt=0, bit_cnt=0; line=1 -> IDLE (glitch rejected, no outputs).
- DATA:
  - On each tick where sample_cnt reaches OVERSAMPLE-1 (next mid-bit), shift the line into rx_data[bit_cnt] (LSB first) and increment bit_cnt.
  - After bit DATA_BITS-1: -> PARITY if PARITY_EN, else -> STOP.
  - rx_data is cleared to 0 on entry to DATA.
- PARITY:
  - At mid-bit, latch the line into parity_bit.
  - parity_load=1 for exactly the next clk, with rx_data and parity_bit stable.
  - -> STOP.
  - Checker convention is even parity: error when parity_bit != ^rx_data.
- Parity error capture:
  - par_err_in is captured into an internal flag on the clk after parity_load.
  - The flag is cleared on START entry and held until STOP.
- STOP, at mid-bit:
  - Line=1: data_valid=1 for one clk; parity_error = captured flag (0 when PARITY_EN=0).
  - Line=0: framing_error=1 for one clk; data_valid=0, parity_error=0.
  - Either way -> IDLE.
  - A new start needs a fresh falling edge, so a held-low break yields one framing_error only.
- Latency: data_valid asserts one clk after the stop-bit mid-sample tick.
- rx_data holds the last frame until the next DATA entry.
- baud_tick coincident with the IDLE falling edge: the edge is taken; counting starts at the next tick.
- rx_in changes between ticks are ignored except for IDLE edge detection.
- busy deasserts in the same clk that data_valid or framing_error pulses.

Test Plan:
- Frame 0xA5, parity bit 0, stop 1, baud_tick every 4 clk -> one data_valid pulse, rx_data=0xA5, parity_error=0, framing_error=0, exactly one parity_load.
- Frame 0x01, parity bit 0, with par_err_in driven by a reference even-parity model -> data_valid=1 and parity_error=1 in the same clk, rx_data=0x01.
- Frame 0x3C, parity bit 0, stop bit 0, line held low for 3 bit times -> single framing_error pulse, no data_valid, busy=0 afterwards; a following 0x55 frame is received correctly.
- rx_in low for 4 ticks then high (glitch) -> return to IDLE; no parity_load, data_valid or framing_error.
- rst_n pulsed low during data bit 3 of frame 0xFF -> all outputs 0 immediately; the next frame 0x12 is received with data_valid and rx_data=0x12.
- PARITY_EN=0, DATA_BITS=7, back-to-back frames 0x7F, 0x00 -> two data_valid pulses, rx_data=0x7F then 0x00, parity_load never asserted.
